// File: rtl/mmio_uart_tx.sv
// MMIO console UART transmitter: byte FIFO feeding an 8N1 serializer, LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the eighth data bit.
//
// state  | meaning
// IDLE   | line high, pops the next byte as soon as the FIFO is non-empty
// START  | start bit (low)
// DATA   | eight data bits, LSB first
// PARITY | even parity over the byte (UART_TX_PARITY_EN only)
// STOP   | stop bit (high)
module mmio_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          Rst_n,
    input  logic                          mem_hold,
    input  logic                          mmio_wea,
    input  logic [31:0]                   mmio_dat,
    output logic                          mmio_read,
    output logic                          tx,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
`ifdef UART_TX_PARITY_EN
        , S_PARITY
`endif
    } state_t;

    state_t          state, state_nxt;
    logic [BW-1:0]   baud_cnt, baud_nxt;
    logic [2:0]      bit_idx, bit_nxt;
    logic [7:0]      frame_byte;
    logic [7:0]      fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic            push, pop, full, tx_nxt, baud_last;
    logic            unused_dat;

    assign unused_dat = ^mmio_dat[31:8];

    // Full is judged on the registered count, so a push into a full FIFO is
    // dropped even when a pop happens in the same cycle.
    assign full      = (fifo_count == CW'(FIFO_DEPTH));
    assign push      = mmio_wea & ~mem_hold & ~full;
    assign mmio_read = ~full;
    assign tx_busy   = (fifo_count != '0) | (state != S_IDLE);
    assign baud_last = (baud_cnt == BW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= mmio_dat[7:0];
    end

    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (mmio_wea & ~mem_hold & full) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state      <= S_IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            frame_byte <= '0;
            tx         <= 1'b1;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_nxt;
            bit_idx  <= bit_nxt;
            tx       <= tx_nxt;
            if (pop) frame_byte <= fifo_mem[rd_ptr];
        end
    end

    // tx is registered from the current state, so the line trails the FSM by one cycle.
    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt + BW'(1);
        bit_nxt   = bit_idx;
        tx_nxt    = 1'b1;
        pop       = 1'b0;
        case (state)
            S_IDLE: begin
                baud_nxt = '0;
                if (fifo_count != '0) begin
                    pop       = 1'b1;
                    state_nxt = S_START;
                end
            end
            S_START: begin
                tx_nxt = 1'b0;
                if (baud_last) begin
                    baud_nxt  = '0;
                    bit_nxt   = '0;
                    state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                tx_nxt = frame_byte[bit_idx];
                if (baud_last) begin
                    baud_nxt = '0;
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_nxt = S_PARITY;
`else
                        state_nxt = S_STOP;
`endif
                    end else begin
                        bit_nxt = bit_idx + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                tx_nxt = ^frame_byte;
                if (baud_last) begin
                    baud_nxt  = '0;
                    state_nxt = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (baud_last) begin
                    baud_nxt  = '0;
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                baud_nxt  = '0;
                state_nxt = S_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: accepted bytes queue up as expected frames,
// a serial-line monitor decodes tx independently and compares.
module tb_mmio_uart_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          Rst_n = 1'b0;
    logic          mem_hold = 1'b0;
    logic          mmio_wea = 1'b0;
    logic [31:0]   mmio_dat = '0;
    logic          mmio_read, tx, tx_busy, overflow;
    logic [CW-1:0] fifo_count;

    int            vectors = 0;
    int            miscompares = 0;
    logic [7:0]    exp_q[$];
    bit            mon_en = 1'b0;

    mmio_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .Rst_n(Rst_n), .mem_hold(mem_hold), .mmio_wea(mmio_wea),
        .mmio_dat(mmio_dat), .mmio_read(mmio_read), .tx(tx), .tx_busy(tx_busy),
        .fifo_count(fifo_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] b, input logic hold, input logic accept);
        mmio_wea = 1'b1;
        mem_hold = hold;
        mmio_dat = {24'($urandom), b};
        if (accept) exp_q.push_back(b);
        tick();
        mmio_wea = 1'b0;
        mem_hold = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            tick();
            t++;
        end
        chk("drain_done", 32'(exp_q.size()), 0);
        repeat (8) tick();
        chk("idle_busy", tx_busy, 0);
        chk("idle_tx", tx, 1);
    endtask

    // serial receiver: samples each bit in the middle of its CPB-cycle window
    initial begin
        logic [7:0] d;
        logic [7:0] e;
`ifdef UART_TX_PARITY_EN
        logic p;
`endif
        forever begin
            @(negedge tx);
            if (!mon_en) continue;
            repeat (2) @(posedge clk);
            #1;
            chk("start_bit", tx, 0);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(posedge clk);
                #1;
                d[i] = tx;
            end
`ifdef UART_TX_PARITY_EN
            repeat (CPB) @(posedge clk);
            #1;
            p = tx;
`endif
            repeat (CPB) @(posedge clk);
            #1;
            chk("stop_bit", tx, 1);
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_byte: got %02h expected none", d);
            end else begin
                e = exp_q.pop_front();
                chk("rx_byte", d, e);
`ifdef UART_TX_PARITY_EN
                chk("parity_bit", p, ($countones(e) % 2 == 1) ? 1 : 0);
`endif
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int fill_cnt[5] = '{1, 1, 2, 3, 4};
        int n_sent;
        int guard;
        logic hold;
        logic [7:0] b;

        repeat (3) tick();
        Rst_n = 1'b1;
        tick();
        chk("rst_tx", tx, 1);
        chk("rst_ready", mmio_read, 1);
        chk("rst_count", fifo_count, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_busy", tx_busy, 0);

        // reset asserted in the middle of a frame with bytes still queued
        wr(8'h5A, 0, 0);
        wr(8'h3C, 0, 0);
        wr(8'hC3, 0, 0);
        repeat (10) tick();
        chk("mid_busy", tx_busy, 1);
        chk("mid_count", fifo_count, 2);
        Rst_n = 1'b0;
        #1;
        chk("arst_tx", tx, 1);
        chk("arst_ready", mmio_read, 1);
        chk("arst_count", fifo_count, 0);
        chk("arst_ovf", overflow, 0);
        chk("arst_busy", tx_busy, 0);
        Rst_n = 1'b1;
        repeat (2) tick();
        mon_en = 1'b1;

        // single byte latency and frame length
        wr(8'hA5, 0, 1);
        chk("lat_n0_tx", tx, 1);
        chk("lat_n0_busy", tx_busy, 1);
        tick();
        chk("lat_n1_tx", tx, 1);
        tick();
        chk("lat_n2_tx", tx, 0);
        repeat (38) tick();
        chk("busy_in_stop", tx_busy, 1);
        repeat (2) tick();
        chk("busy_after_frame", tx_busy, 0);
        chk("tx_after_frame", tx, 1);
        wait_drain();

        // fill to full, then overflow
        for (int i = 0; i < 5; i++) begin
            wr(8'(i + 1), 0, 1);
            chk("fill_count", fifo_count, 32'(fill_cnt[i]));
            chk("fill_ovf", overflow, 0);
        end
        chk("full_ready", mmio_read, 0);
        wr(8'h06, 0, 0);
        chk("ovf_set", overflow, 1);
        chk("ovf_count", fifo_count, 4);
        chk("ovf_ready", mmio_read, 0);
        wait_drain();
        chk("ovf_sticky", overflow, 1);
        Rst_n = 1'b0;
        tick();
        Rst_n = 1'b1;
        tick();
        chk("ovf_cleared", overflow, 0);

        // stalled writes are ignored
        for (int i = 0; i < 3; i++) begin
            wr(8'($urandom), 1, 0);
            chk("hold_count", fifo_count, 0);
            chk("hold_tx", tx, 1);
        end
        repeat (4) tick();
        chk("hold_tx_late", tx, 1);
        chk("hold_ovf", overflow, 0);

        // random stream with stalls and gaps, wrapping the FIFO pointers many times
        n_sent = 0;
        guard = 0;
        while (n_sent < 20 && guard < 5000) begin
            guard++;
            repeat ($urandom_range(0, 3)) tick();
            if (!mmio_read) begin
                tick();
                continue;
            end
            hold = ($urandom_range(0, 3) == 0);
            b = 8'($urandom);
            wr(b, hold, !hold);
            if (!hold) n_sent++;
        end
        chk("rand_sent", 32'(n_sent), 20);
        wait_drain();
        chk("rand_ovf", overflow, 0);

`ifdef UART_TX_PARITY_EN
        wr(8'h03, 0, 1);
        wait_drain();
        wr(8'h07, 0, 1);
        wait_drain();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
